// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB power-up register sequencer.
package sccb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT,
      ST_DELAY,
      ST_NEXT,
      ST_DONE,
      ST_ERROR
   } sccb_state_e;

   localparam logic [15:0] SCCB_END        = 16'hFFFF;
   localparam logic [7:0]  SCCB_DELAY_ADDR = 8'hFF;
   localparam logic [7:0]  OV7670_WR_ID    = 8'h42;

   // Default OV7670 bring-up table; entry 0 sits in the low halfword.
   localparam logic [255:0] OV7670_DEFAULT_TBL = {
      16'hFFFF, 16'h523D, 16'h5100, 16'h50B3,
      16'h4FB3, 16'h1418, 16'h3A04, 16'h0400,
      16'h8C00, 16'h40D0, 16'h3E19, 16'h0C04,
      16'h1101, 16'h1214, 16'hFF0A, 16'h1280
   };

endpackage

// File: rtl/sccb_cfg_rom.sv
// Registered-read {addr, data} table for the SCCB sequencer; entry i is INIT[16*i +: 16].
module sccb_cfg_rom #(
   parameter int unsigned               NUM_ENTRIES = 16,
   parameter int unsigned               AW          = 4,
   parameter logic [NUM_ENTRIES*16-1:0] INIT        = '0
) (
   input  logic          i_clk,
   input  logic [AW-1:0] i_addr,
   output logic [15:0]   o_data
);

   logic [15:0] r_data;

   always_ff @(posedge i_clk) begin
      r_data <= INIT[16*i_addr +: 16];
   end

   assign o_data = r_data;

endmodule

// File: rtl/sccb_init_seq.sv
// Walks a register table and issues SCCB writes with delays and NACK handling.
// Optional NACK retries are enabled by defining SCCB_SEQ_RETRY_EN.
module sccb_init_seq
   import sccb_pkg::*;
#(
   parameter logic [7:0]                DEV_ID      = OV7670_WR_ID,
   parameter int unsigned               NUM_ENTRIES = 16,
   parameter int unsigned               DELAY_UNIT  = 10000,
   parameter int unsigned               MAX_RETRY   = 3,
   parameter logic [NUM_ENTRIES*16-1:0] ROM_INIT    = OV7670_DEFAULT_TBL
) (
   input  logic       SYSCLK,
   input  logic       DEVRST_N,
   input  logic       start,
   output logic       tx_req,
   output logic [7:0] tx_id,
   output logic [7:0] tx_addr,
   output logic [7:0] tx_data,
   input  logic       tx_ack,
   input  logic       tx_nack,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned AW      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int unsigned DW      = $clog2(255 * DELAY_UNIT + 1);
   // DELAY leaves early by the NEXT + two FETCH cycles so data*DELAY_UNIT spans DELAY entry to the next request.
   localparam int unsigned DLY_OVH = 3;

   sccb_state_e   r_state, w_state_nxt;
   logic [AW-1:0] r_idx, w_idx_nxt;
   logic          r_fetch_ph, w_fetch_ph_nxt;
   logic [DW-1:0] r_dly, w_dly_nxt;
   logic [7:0]    r_tx_id, w_tx_id_nxt;
   logic [7:0]    r_tx_addr, w_tx_addr_nxt;
   logic [7:0]    r_tx_data, w_tx_data_nxt;
   logic [15:0]   w_rom_q;
`ifdef SCCB_SEQ_RETRY_EN
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RW-1:0] r_retry, w_retry_nxt;
`endif

   sccb_cfg_rom #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .AW          (AW),
      .INIT        (ROM_INIT)
   ) u_rom (
      .i_clk  (SYSCLK),
      .i_addr (r_idx),
      .o_data (w_rom_q)
   );

   always_ff @(posedge SYSCLK or negedge DEVRST_N) begin
      if (!DEVRST_N) begin
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_fetch_ph <= 1'b0;
         r_dly      <= '0;
         r_tx_id    <= '0;
         r_tx_addr  <= '0;
         r_tx_data  <= '0;
`ifdef SCCB_SEQ_RETRY_EN
         r_retry    <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_fetch_ph <= w_fetch_ph_nxt;
         r_dly      <= w_dly_nxt;
         r_tx_id    <= w_tx_id_nxt;
         r_tx_addr  <= w_tx_addr_nxt;
         r_tx_data  <= w_tx_data_nxt;
`ifdef SCCB_SEQ_RETRY_EN
         r_retry    <= w_retry_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_fetch_ph_nxt = 1'b0;
      w_dly_nxt      = r_dly;
      w_tx_id_nxt    = r_tx_id;
      w_tx_addr_nxt  = r_tx_addr;
      w_tx_data_nxt  = r_tx_data;
`ifdef SCCB_SEQ_RETRY_EN
      w_retry_nxt    = r_retry;
`endif
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               w_state_nxt = ST_FETCH;
               w_idx_nxt   = '0;
`ifdef SCCB_SEQ_RETRY_EN
               w_retry_nxt = '0;
`endif
            end
         end
         ST_FETCH: begin
            // First cycle issues the ROM read, second cycle decodes its output.
            if (!r_fetch_ph) begin
               w_fetch_ph_nxt = 1'b1;
            end else if (w_rom_q == SCCB_END) begin
               w_state_nxt = ST_DONE;
            end else if (w_rom_q[15:8] == SCCB_DELAY_ADDR) begin
               w_state_nxt = ST_DELAY;
               w_dly_nxt   = DW'(w_rom_q[7:0]) * DW'(DELAY_UNIT);
            end else begin
               w_state_nxt   = ST_ISSUE;
               w_tx_id_nxt   = DEV_ID;
               w_tx_addr_nxt = w_rom_q[15:8];
               w_tx_data_nxt = w_rom_q[7:0];
            end
         end
         ST_ISSUE, ST_WAIT: begin
            if (tx_nack) begin
`ifdef SCCB_SEQ_RETRY_EN
               if (r_retry == RW'(MAX_RETRY)) begin
                  w_state_nxt = ST_ERROR;
               end else begin
                  w_retry_nxt = r_retry + RW'(1);
                  w_state_nxt = ST_FETCH;
               end
`else
               w_state_nxt = ST_ERROR;
`endif
            end else if (tx_ack) begin
               w_state_nxt = ST_NEXT;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_DELAY: begin
            if (r_dly <= DW'(DLY_OVH + 1)) w_state_nxt = ST_NEXT;
            else                           w_dly_nxt   = r_dly - DW'(1);
         end
         ST_NEXT: begin
`ifdef SCCB_SEQ_RETRY_EN
            w_retry_nxt = '0;
`endif
            if (r_idx == AW'(NUM_ENTRIES - 1)) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_idx_nxt   = r_idx + AW'(1);
               w_state_nxt = ST_FETCH;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign tx_req  = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
   assign busy    = (r_state == ST_FETCH) || (r_state == ST_ISSUE) || (r_state == ST_WAIT) ||
                    (r_state == ST_DELAY) || (r_state == ST_NEXT);
   assign done    = (r_state == ST_DONE);
   assign err     = (r_state == ST_ERROR);
   assign tx_id   = r_tx_id;
   assign tx_addr = r_tx_addr;
   assign tx_data = r_tx_data;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Scoreboard bench for sccb_init_seq: directed tables, ack/nack responder, write monitor.
module tb_sccb_init_seq;

   localparam int RSP_ACK  = 0;
   localparam int RSP_NACK = 1;
   localparam int RSP_NONE = 2;
   localparam int RSP_BOTH = 3;

   // Entries: 0 = 12/80, 1 = delay 2 ticks, 2 = 11/01, 3 = end marker.
   localparam logic [255:0] TBL = {{12{16'hFFFF}}, 16'hFFFF, 16'h1101, 16'hFF02, 16'h1280};
   localparam logic [31:0]  TBL_END = {16'h1234, 16'hFFFF};

   typedef struct packed {
      logic [7:0] id;
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       SYSCLK = 1'b0;
   logic       DEVRST_N;
   logic       start, start_e;
   logic       tx_ack, tx_nack;
   logic       tx_req, busy, done, err;
   logic [7:0] tx_id, tx_addr, tx_data;
   logic       tx_req_e, busy_e, done_e, err_e;
   logic [7:0] tx_id_e, tx_addr_e, tx_data_e;

   int  n_cmp = 0;
   int  n_err = 0;
   int  cyc   = 0;
   int  wr_cnt = 0;
   logic saw_req_e = 1'b0;
   wr_t exp_q[$];
   int  resp_q[$];
   int  req_cyc_q[$];
   int  ack_q[$];

   always #5 SYSCLK = ~SYSCLK;
   always @(posedge SYSCLK) cyc <= cyc + 1;
   always @(posedge SYSCLK) if (tx_req_e) saw_req_e <= 1'b1;

   sccb_init_seq #(
      .DEV_ID      (8'h42),
      .NUM_ENTRIES (16),
      .DELAY_UNIT  (10),
      .MAX_RETRY   (3),
      .ROM_INIT    (TBL)
   ) dut (
      .SYSCLK   (SYSCLK),
      .DEVRST_N (DEVRST_N),
      .start    (start),
      .tx_req   (tx_req),
      .tx_id    (tx_id),
      .tx_addr  (tx_addr),
      .tx_data  (tx_data),
      .tx_ack   (tx_ack),
      .tx_nack  (tx_nack),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   sccb_init_seq #(
      .NUM_ENTRIES (2),
      .ROM_INIT    (TBL_END)
   ) dut_end (
      .SYSCLK   (SYSCLK),
      .DEVRST_N (DEVRST_N),
      .start    (start_e),
      .tx_req   (tx_req_e),
      .tx_id    (tx_id_e),
      .tx_addr  (tx_addr_e),
      .tx_data  (tx_data_e),
      .tx_ack   (1'b0),
      .tx_nack  (1'b0),
      .busy     (busy_e),
      .done     (done_e),
      .err      (err_e)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic fail(input string nm, input string why);
      n_cmp++;
      n_err++;
      $display("FAIL %s: %s", nm, why);
   endtask

   task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
      wr_t w;
      w.id = 8'h42; w.addr = a; w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic clr_logs();
      wr_cnt = 0;
      req_cyc_q.delete();
      ack_q.delete();
      resp_q.delete();
   endtask

   task automatic pulse_start(output int edge_o);
      @(negedge SYSCLK); start = 1'b1; edge_o = cyc + 1;
      @(negedge SYSCLK); start = 1'b0;
   endtask

   task automatic wait_end(input string nm, input int lim);
      int n = 0;
      while (!(done || err) && n < lim) begin @(negedge SYSCLK); n++; end
      if (!(done || err)) fail(nm, "timeout waiting for done/err");
   endtask

   task automatic wait_wr(input string nm, input int k, input int lim);
      int n = 0;
      while (wr_cnt < k && n < lim) begin @(negedge SYSCLK); n++; end
      if (wr_cnt < k) fail(nm, "timeout waiting for tx_req");
   endtask

   // Responder: answers each new request 5 cycles later according to resp_q.
   initial begin
      logic prev = 1'b0;
      int   kind;
      tx_ack = 1'b0; tx_nack = 1'b0;
      forever begin
         @(negedge SYSCLK);
         if (tx_req && !prev) begin
            kind = (resp_q.size() > 0) ? resp_q.pop_front() : RSP_ACK;
            if (kind != RSP_NONE) begin
               repeat (4) @(negedge SYSCLK);
               tx_ack  = (kind == RSP_ACK)  || (kind == RSP_BOTH);
               tx_nack = (kind == RSP_NACK) || (kind == RSP_BOTH);
               ack_q.push_back(cyc + 1);
               @(negedge SYSCLK);
               tx_ack = 1'b0; tx_nack = 1'b0;
            end
         end
         prev = tx_req;
      end
   end

   // Monitor: pops the expected write on each request and checks it holds steady.
   initial begin
      logic prev = 1'b0;
      logic have = 1'b0;
      wr_t  cur;
      forever begin
         @(negedge SYSCLK);
         if (tx_req && !prev) begin
            wr_cnt++;
            req_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               have = 1'b0;
               fail("unexpected_write", $sformatf("got %h/%h/%h, want none", tx_id, tx_addr, tx_data));
            end else begin
               cur  = exp_q.pop_front();
               have = 1'b1;
               chk("write_fields", {8'h0, tx_id, tx_addr, tx_data}, {8'h0, cur});
            end
         end else if (tx_req && have) begin
            chk("write_stable", {8'h0, tx_id, tx_addr, tx_data}, {8'h0, cur});
         end
         prev = tx_req;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int se, dummy, d;
      DEVRST_N = 1'b0; start = 1'b0; start_e = 1'b0;
      repeat (3) @(negedge SYSCLK);
      chk("rst_flags", {28'h0, tx_req, busy, done, err}, 32'h0);
      chk("rst_fields", {8'h0, tx_id, tx_addr, tx_data}, 32'h0);
      DEVRST_N = 1'b1;
      repeat (2) @(negedge SYSCLK);
      chk("idle_flags", {29'h0, busy, done, err}, 32'h0);

      // End marker at entry 0.
      @(negedge SYSCLK); start_e = 1'b1;
      @(negedge SYSCLK); start_e = 1'b0;
      @(negedge SYSCLK); chk("end0_not_yet", {31'h0, done_e}, 32'h0);
      @(negedge SYSCLK); chk("end0_done_busy", {30'h0, done_e, busy_e}, 32'h2);

      // Two writes with a 20-cycle delay entry; a start mid-write must be ignored.
      clr_logs();
      exp_wr(8'h12, 8'h80); exp_wr(8'h11, 8'h01);
      resp_q.push_back(RSP_ACK); resp_q.push_back(RSP_ACK);
      pulse_start(se);
      wait_wr("s1_first_req", 1, 50);
      pulse_start(dummy);
      wait_end("s1_end", 400);
      chk("s1_flags", {29'h0, busy, done, err}, 32'h2);
      chk("s1_writes", wr_cnt, 2);
      chk("s1_exp_left", exp_q.size(), 0);
      if (req_cyc_q.size() >= 2 && ack_q.size() >= 1) begin
         chk("s1_req_latency", req_cyc_q[0] - se, 2);
         d = req_cyc_q[1] - (ack_q[0] + 3);
         chk_rng("s1_delay_gap", d, 19, 21);
      end else begin
         fail("s1_logs", "missing request/ack timestamps");
      end

      // Restart after done replays from entry 0.
      clr_logs();
      exp_wr(8'h12, 8'h80); exp_wr(8'h11, 8'h01);
      pulse_start(se);
      chk("s2_start_clears_done", {30'h0, done, busy}, 32'h1);
      wait_end("s2_end", 400);
      chk("s2_flags", {29'h0, busy, done, err}, 32'h2);
      chk("s2_writes", wr_cnt, 2);

`ifdef SCCB_SEQ_RETRY_EN
      clr_logs();
      repeat (4) exp_wr(8'h12, 8'h80);
      exp_wr(8'h11, 8'h01);
      repeat (3) resp_q.push_back(RSP_NACK);
      resp_q.push_back(RSP_ACK); resp_q.push_back(RSP_ACK);
      pulse_start(se);
      wait_end("s3_retry_end", 600);
      chk("s3_retry_flags", {29'h0, busy, done, err}, 32'h2);
      chk("s3_retry_writes", wr_cnt, 5);

      clr_logs();
      repeat (4) exp_wr(8'h12, 8'h80);
      repeat (4) resp_q.push_back(RSP_NACK);
      pulse_start(se);
      wait_end("s3_exhaust_end", 600);
      repeat (20) @(negedge SYSCLK);
      chk("s3_exhaust_flags", {29'h0, busy, done, err}, 32'h1);
      chk("s3_exhaust_writes", wr_cnt, 4);

      clr_logs();
      exp_wr(8'h12, 8'h80); exp_wr(8'h12, 8'h80); exp_wr(8'h11, 8'h01);
      resp_q.push_back(RSP_BOTH); resp_q.push_back(RSP_ACK); resp_q.push_back(RSP_ACK);
      pulse_start(se);
      wait_end("s4_both_end", 600);
      chk("s4_both_flags", {29'h0, busy, done, err}, 32'h2);
      chk("s4_both_writes", wr_cnt, 3);
`else
      clr_logs();
      exp_wr(8'h12, 8'h80);
      resp_q.push_back(RSP_NACK);
      pulse_start(se);
      wait_end("s3_nack_end", 200);
      repeat (20) @(negedge SYSCLK);
      chk("s3_nack_flags", {29'h0, busy, done, err}, 32'h1);
      chk("s3_nack_writes", wr_cnt, 1);

      clr_logs();
      exp_wr(8'h12, 8'h80);
      resp_q.push_back(RSP_BOTH);
      pulse_start(se);
      wait_end("s4_both_end", 200);
      repeat (20) @(negedge SYSCLK);
      chk("s4_both_flags", {29'h0, busy, done, err}, 32'h1);
      chk("s4_both_writes", wr_cnt, 1);
`endif
      chk("s4_exp_left", exp_q.size(), 0);

      // Reset while waiting for an ack that never comes.
      clr_logs();
      exp_wr(8'h12, 8'h80);
      resp_q.push_back(RSP_NONE);
      pulse_start(se);
      wait_wr("s5_req", 1, 50);
      repeat (2) @(negedge SYSCLK);
      chk("s5_waiting", {30'h0, tx_req, busy}, 32'h3);
      DEVRST_N = 1'b0;
      #1;
      chk("s5_rst_drop", {30'h0, tx_req, busy}, 32'h0);
      @(negedge SYSCLK); DEVRST_N = 1'b1;
      repeat (10) @(negedge SYSCLK);
      chk("s5_stay_idle", {28'h0, tx_req, busy, done, err}, 32'h0);
      chk("s5_writes", wr_cnt, 1);
      chk("s5_exp_left", exp_q.size(), 0);

      // Start after reset runs the full table again.
      clr_logs();
      exp_wr(8'h12, 8'h80); exp_wr(8'h11, 8'h01);
      pulse_start(se);
      wait_end("s6_end", 400);
      chk("s6_flags", {29'h0, busy, done, err}, 32'h2);
      chk("s6_writes", wr_cnt, 2);
      chk("s6_exp_left", exp_q.size(), 0);

      chk("end0_no_req", {31'h0, saw_req_e}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
